branch_predictor: RTL
=====================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/data width.
REQ-002 SHALL have parameter ENTRIES, default 16, table depth; power of two, >=2.
REQ-003 SHALL derive IDX_W = log2(ENTRIES) and TAG_W = XLEN-IDX_W-2 as localparams.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port if_pc  input  XLEN  fetch-stage PC to predict.
REQ-007 SHALL have port pred_hit  output  1  valid entry with matching tag found for if_pc.
REQ-008 SHALL have port pred_taken  output  1  predicted taken.
REQ-009 SHALL have port pred_target  output  XLEN  predicted next PC.
REQ-010 SHALL have port upd_valid  input  1  decode-stage branch resolved this cycle.
REQ-011 SHALL have port upd_pc  input  XLEN  PC of resolved branch.
REQ-012 SHALL have port upd_taken  input  1  actual outcome.
REQ-013 SHALL have port upd_target  input  XLEN  actual taken target.
REQ-014 SHALL have port inval  input  1  invalidate whole table (fence.i).

Function
REQ-015 SHALL index with pc[IDX_W+1:2] and tag with pc[XLEN-1:IDX_W+2]; pc[1:0] ignored.
REQ-016 SHALL store per entry: valid, tag, target, 2-bit saturating counter (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
REQ-017 SHALL generate lookup combinationally from registered state, with zero-cycle latency.
REQ-018 SHALL assert pred_hit iff entry valid and tag equal; pred_taken = pred_hit & counter[1].
REQ-019 SHALL drive pred_target = stored target when pred_taken, else if_pc+4 (modulo 2^XLEN wrap).
REQ-020 SHALL, on upd_valid with hit and upd_taken, increment counter saturating at 11 and write target.
REQ-021 SHALL, on upd_valid with hit and !upd_taken, decrement counter saturating at 00; target unchanged.
REQ-022 SHALL, on upd_valid with miss and upd_taken, allocate: valid=1, tag, target, counter=10, overwriting any aliasing entry.
REQ-023 SHALL, on upd_valid with miss and !upd_taken, leave the table unchanged (no allocation).
REQ-024 SHALL make an update visible to lookup the cycle after the edge; same-cycle lookup of the same index sees old contents.
REQ-025 SHALL, on inval, clear all valid bits at the edge; inval and upd_valid in the same cycle: inval wins, the update is dropped.
REQ-026 SHALL never modify any entry other than the indexed one on an update.

Reset
REQ-027 SHALL, while reset low, clear all valid bits, set counters to 01 and targets/tags to 0, asynchronously.
REQ-028 SHALL, after reset, output pred_hit=0, pred_taken=0 and pred_target=if_pc+4.
REQ-029 SHALL, on reset asserted mid-update, discard the update; the table equals its reset state on release.

Structure
REQ-030 SHALL place the counter encoding constants (SNT, WNT, WT, ST) and the saturating increment/decrement functions in package bp_pkg.
REQ-031 SHALL implement per-entry storage in one sub-module bp_entry (valid/tag/target/counter register with update logic), instantiated ENTRIES times.
REQ-032 SHALL connect in the core to pc_src/branch_logic: the predictor replaces pc+4 at the PC mux, and the decode stage flushes IF/ID on mispredict and drives upd_*.

Verification
REQ-033 SHALL check: reset, then if_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x44.
REQ-034 SHALL check: update pc=0x40 taken target=0x100, then lookup 0x40 next cycle -> hit=1, taken=1, target=0x100, counter=10.
REQ-035 SHALL check: from counter 10 apply two not-taken updates -> counter 00, taken=0, target=0x44; a third not-taken leaves it at 00 (saturation); four taken updates end at 11.
REQ-036 SHALL check aliasing (ENTRIES=16): allocate 0x40, then taken update 0x80 (same index 0) -> lookup 0x40 hit=0, 0x80 hit=1.
REQ-037 SHALL check: inval and upd_valid (pc=0x40, taken) in the same cycle -> all lookups hit=0 afterward.
REQ-038 SHALL check: reset asserted asynchronously between edges during upd_valid -> outputs return to reset values immediately; no entry is allocated.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared encodings and helpers for the branch predictor table.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package bp_pkg;

    // Two-bit saturating counter encodings; bit 1 is the taken prediction.
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Step toward strong-taken, holding at ST.
    function automatic logic [1:0] sat_inc(input logic [1:0] ctr);
        return (ctr == ST) ? ST : ctr + 2'd1;
    endfunction

    // Step toward strong-not-taken, holding at SNT.
    function automatic logic [1:0] sat_dec(input logic [1:0] ctr);
        return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/bp_entry.sv
// One predictor slot: valid/tag/target/counter with its own update rules.
// Latency: update visible one cycle after the edge that samples sel.
// Backpressure: none; every selected update is applied unless inval or reset.
module bp_entry
    import bp_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inval,
    input  logic             sel,
    input  logic             upd_taken,
    input  logic [TAG_W-1:0] upd_tag,
    input  logic [XLEN-1:0]  upd_target,
    output logic             valid,
    output logic [TAG_W-1:0] tag,
    output logic [XLEN-1:0]  target,
    output logic             ctr_taken
);

    logic [1:0] ctr;
    logic       upd_hit;

    assign upd_hit   = valid && (tag == upd_tag);
    assign ctr_taken = ctr[1];

    // Reset/invalidate/train/allocate; inval beats any update in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid  <= 1'b0;
            tag    <= '0;
            target <= '0;
            ctr    <= WNT;
        end else if (inval) begin
            valid <= 1'b0;
        end else if (sel) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    ctr    <= sat_inc(ctr);
                    target <= upd_target;
                end else begin
                    ctr <= sat_dec(ctr);
                end
            end else if (upd_taken) begin
                // Allocate on a taken miss, evicting whatever aliased here.
                valid  <= 1'b1;
                tag    <= upd_tag;
                target <= upd_target;
                ctr    <= WT;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; combinational lookup of if_pc.
// Latency: prediction same cycle; updates visible the cycle after the edge.
// Backpressure: none; one update per cycle is always accepted.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            inval
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_pc_unused;

    logic             e_valid  [ENTRIES];
    logic [TAG_W-1:0] e_tag    [ENTRIES];
    logic [XLEN-1:0]  e_target [ENTRIES];
    logic             e_taken  [ENTRIES];

    // Instruction alignment bits carry no index or tag information.
    assign if_idx        = if_pc[IDX_W+1:2];
    assign if_tag        = if_pc[XLEN-1:IDX_W+2];
    assign upd_idx       = upd_pc[IDX_W+1:2];
    assign upd_tag       = upd_pc[XLEN-1:IDX_W+2];
    assign upd_pc_unused = ^upd_pc[1:0];

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        bp_entry #(
            .XLEN  (XLEN),
            .TAG_W (TAG_W)
        ) u_entry (
            .clk        (clk),
            .reset      (reset),
            .inval      (inval),
            .sel        (upd_valid && (upd_idx == IDX_W'(i))),
            .upd_taken  (upd_taken),
            .upd_tag    (upd_tag),
            .upd_target (upd_target),
            .valid      (e_valid[i]),
            .tag        (e_tag[i]),
            .target     (e_target[i]),
            .ctr_taken  (e_taken[i])
        );
    end

    // Lookup straight from registered state; fall through to pc+4 unless taken.
    always_comb begin
        pred_hit    = e_valid[if_idx] && (e_tag[if_idx] == if_tag);
        pred_taken  = pred_hit && e_taken[if_idx];
        pred_target = pred_taken ? e_target[if_idx] : if_pc + XLEN'(4);
    end

endmodule
